// File: rtl/pipeline_run_ctl.sv
// Run/step/breakpoint sequencer that drives the pipeline clock enable.
// Debounces the STEP and RUN buttons, halts on a PC breakpoint and counts enabled cycles.
//
// Ports:
//   i_clk, i_rst_n          clock, async active-low reset
//   i_btn_step, i_btn_run   raw board buttons (async, active-high)
//   i_bp_en, i_bp_addr      breakpoint enable and PC
//   i_pc_f                  fetch-stage PC
//   o_clk_en                pipeline clock enable (decoded from the state register)
//   o_halted, o_brk_hit     status: HALT/BRK, BRK only
//   o_state                 HALT=00 STEP=01 RUN=10 BRK=11
//   o_cycle_cnt             enabled-cycle count, wraps silently
module pipeline_run_ctl #(
    parameter int DEB_CYCLES = 1000000,
    parameter int DEB_W      = 20,
    parameter int STEP_LEN   = 1,
    parameter int STEP_W     = 4,
    parameter int CNT_W      = 32,
    parameter int XLEN       = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_btn_step,
    input  logic             i_btn_run,
    input  logic             i_bp_en,
    input  logic [XLEN-1:0]  i_bp_addr,
    input  logic [XLEN-1:0]  i_pc_f,
    output logic             o_clk_en,
    output logic             o_halted,
    output logic             o_brk_hit,
    output logic [1:0]       o_state,
    output logic [CNT_W-1:0] o_cycle_cnt
);

    typedef enum logic [1:0] {
        S_HALT = 2'b00,
        S_STEP = 2'b01,
        S_RUN  = 2'b10,
        S_BRK  = 2'b11
    } state_t;

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [STEP_W-1:0] STEP_LOAD = STEP_W'(STEP_LEN);
    localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);

    // Bit 0 = STEP, bit 1 = RUN.
    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [1:0]       lvl;
    logic [DEB_W-1:0] deb_cnt [2];
    logic [1:0]       press;

    state_t            state;
    state_t            state_nx;
    logic [STEP_W-1:0] step_cnt;
    logic [STEP_W-1:0] step_cnt_nx;
    logic              suppress;
    logic              suppress_nx;
    logic              step_p;
    logic              run_p;
    logic              bp_hit;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            lvl   <= '0;
            for (int i = 0; i < 2; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            sync1 <= {i_btn_run, i_btn_step};
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] != lvl[i]) begin
                    if (deb_cnt[i] == DEB_LAST) begin
                        lvl[i]     <= sync2[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 1'b1;
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    // The press pulse coincides with the clock edge on which the debounced
    // level rises, so the FSM reacts on that same edge.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            press[i] = sync2[i] & ~lvl[i] & (deb_cnt[i] == DEB_LAST);
        end
    end

    assign step_p = press[0];
    assign run_p  = press[1];

    assign o_clk_en = (state == S_STEP) || (state == S_RUN);
    assign bp_hit   = i_bp_en & (i_pc_f == i_bp_addr) & o_clk_en & ~suppress;

    always_comb begin
        state_nx    = state;
        step_cnt_nx = step_cnt;
        suppress_nx = suppress;
        unique case (state)
            S_HALT: begin
                if (run_p) begin
                    state_nx = S_RUN;
                end else if (step_p) begin
                    state_nx    = S_STEP;
                    step_cnt_nx = STEP_LOAD;
                end
            end
            S_STEP: begin
                if (run_p) begin
                    state_nx    = S_RUN;
                    step_cnt_nx = '0;
                end else if (step_cnt == STEP_ONE) begin
                    state_nx    = S_HALT;
                    step_cnt_nx = '0;
                end else begin
                    step_cnt_nx = step_cnt - 1'b1;
                end
            end
            S_RUN: begin
                // Suppression only covers the first cycle after leaving BRK.
                suppress_nx = 1'b0;
                if (run_p) begin
                    state_nx = S_HALT;
                end else if (bp_hit) begin
                    state_nx = S_BRK;
                end
            end
            S_BRK: begin
                if (run_p) begin
                    state_nx    = S_RUN;
                    suppress_nx = 1'b1;
                end else if (step_p) begin
                    state_nx    = S_STEP;
                    step_cnt_nx = STEP_LOAD;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= S_HALT;
            step_cnt    <= '0;
            suppress    <= 1'b0;
            o_cycle_cnt <= '0;
        end else begin
            state    <= state_nx;
            step_cnt <= step_cnt_nx;
            suppress <= suppress_nx;
            if (o_clk_en) begin
                o_cycle_cnt <= o_cycle_cnt + 1'b1;
            end
        end
    end

    assign o_state   = state;
    assign o_halted  = (state == S_HALT) || (state == S_BRK);
    assign o_brk_hit = (state == S_BRK);

endmodule

// File: tb/tb_pipeline_run_ctl.sv
// Testbench for pipeline_run_ctl: three instances (STEP_LEN=1/CNT_W=8,
// STEP_LEN=3, CNT_W=4) sharing the buttons, each with its own PC model.
module tb_pipeline_run_ctl;

    localparam logic [1:0] HALT = 2'b00;
    localparam logic [1:0] STEP = 2'b01;
    localparam logic [1:0] RUN  = 2'b10;
    localparam logic [1:0] BRK  = 2'b11;

    logic clk = 1'b0;
    logic rst_n;
    logic btn_step;
    logic btn_run;

    logic        bp_en0, bp_en1, bp_en2;
    logic [31:0] bp_addr0, bp_addr1, bp_addr2;
    logic [31:0] pc0, pc1, pc2;

    logic       en0, en1, en2;
    logic       halt0, halt1, halt2;
    logic       brk0, brk1, brk2;
    logic [1:0] st0, st1, st2;
    logic [7:0] cnt0;
    logic [7:0] cnt1;
    logic [3:0] cnt2;

    int checks = 0;
    int errors = 0;
    int ec0, ec1, ec2;

    always #5 clk = ~clk;

    pipeline_run_ctl #(
        .DEB_CYCLES(4), .DEB_W(3), .STEP_LEN(1), .STEP_W(4), .CNT_W(8), .XLEN(32)
    ) u0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_btn_step(btn_step), .i_btn_run(btn_run),
        .i_bp_en(bp_en0), .i_bp_addr(bp_addr0), .i_pc_f(pc0),
        .o_clk_en(en0), .o_halted(halt0), .o_brk_hit(brk0), .o_state(st0),
        .o_cycle_cnt(cnt0)
    );

    pipeline_run_ctl #(
        .DEB_CYCLES(4), .DEB_W(3), .STEP_LEN(3), .STEP_W(4), .CNT_W(8), .XLEN(32)
    ) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_btn_step(btn_step), .i_btn_run(btn_run),
        .i_bp_en(bp_en1), .i_bp_addr(bp_addr1), .i_pc_f(pc1),
        .o_clk_en(en1), .o_halted(halt1), .o_brk_hit(brk1), .o_state(st1),
        .o_cycle_cnt(cnt1)
    );

    pipeline_run_ctl #(
        .DEB_CYCLES(4), .DEB_W(3), .STEP_LEN(1), .STEP_W(4), .CNT_W(4), .XLEN(32)
    ) u2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_btn_step(btn_step), .i_btn_run(btn_run),
        .i_bp_en(bp_en2), .i_bp_addr(bp_addr2), .i_pc_f(pc2),
        .o_clk_en(en2), .o_halted(halt2), .o_brk_hit(brk2), .o_state(st2),
        .o_cycle_cnt(cnt2)
    );

    typedef struct {
        logic       step;
        logic       run;
        logic       en0;
        logic       en1;
        logic [1:0] st0;
    } vec_t;

    localparam int NV = 36;
    localparam int J0 = 10;
    vec_t tbl [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: the PC model advances after every enabled cycle.
    task automatic tick();
        bit e0, e1, e2;
        e0 = en0;
        e1 = en1;
        e2 = en2;
        @(posedge clk);
        #1;
        if (e0) begin pc0 = pc0 + 32'd4; ec0++; end
        if (e1) begin pc1 = pc1 + 32'd4; ec1++; end
        if (e2) begin pc2 = pc2 + 32'd4; ec2++; end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [1:0] st_of(input int k);
        case (k)
            0: return st0;
            1: return st1;
            default: return st2;
        endcase
    endfunction

    task automatic wait_st(input int k, input logic [1:0] st, input bit neq,
                           input int budget, input string nm);
        int n;
        n = 0;
        while (((st_of(k) == st) == neq) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if ((st_of(k) == st) == neq) begin
            errors++;
            $display("FAIL %s: timeout, state %0b expected %s%0b", nm, st_of(k),
                     neq ? "not " : "", st);
        end
    endtask

    task automatic clr_model();
        pc0 = 0; pc1 = 0; pc2 = 0;
        ec0 = 0; ec1 = 0; ec2 = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Rows 0-2: 3-cycle RUN glitch; rows J0..J0+9: STEP held 10 cycles.
        for (int i = 0; i < NV; i++) begin
            tbl[i] = '{step: 1'b0, run: 1'b0, en0: 1'b0, en1: 1'b0, st0: HALT};
            if (i < 3) tbl[i].run = 1'b1;
            if (i >= J0 && i < J0 + 10) tbl[i].step = 1'b1;
        end
        tbl[J0+5].en0 = 1'b1;
        tbl[J0+5].st0 = STEP;
        tbl[J0+5].en1 = 1'b1;
        tbl[J0+6].en1 = 1'b1;
        tbl[J0+7].en1 = 1'b1;

        rst_n = 1'b0;
        btn_step = 1'b0;
        btn_run = 1'b0;
        bp_en0 = 1'b0; bp_en1 = 1'b0; bp_en2 = 1'b0;
        bp_addr0 = '0; bp_addr1 = '0; bp_addr2 = '0;
        clr_model();

        idle(2);
        chk("rst_state", 32'(st0), 32'(HALT));
        chk("rst_clk_en", 32'(en0), 0);
        chk("rst_halted", 32'(halt0), 1);
        chk("rst_brk_hit", 32'(brk0), 0);
        chk("rst_cnt", 32'(cnt0), 0);
        rst_n = 1'b1;

        // Glitch rejection and single/multi step.
        for (int i = 0; i < NV; i++) begin
            btn_step = tbl[i].step;
            btn_run  = tbl[i].run;
            tick();
            chk($sformatf("vec%0d_en0", i), 32'(en0), 32'(tbl[i].en0));
            chk($sformatf("vec%0d_en1", i), 32'(en1), 32'(tbl[i].en1));
            chk($sformatf("vec%0d_st0", i), 32'(st0), 32'(tbl[i].st0));
        end
        chk("step1_cnt", 32'(cnt0), 1);
        chk("step3_cnt", 32'(cnt1), 3);
        chk("step3_state", 32'(st1), 32'(HALT));

        // Breakpoint at 0x10 from a fresh reset.
        rst_n = 1'b0;
        clr_model();
        idle(2);
        rst_n = 1'b1;
        bp_en0 = 1'b1;
        bp_addr0 = 32'h10;
        idle(2);
        btn_run = 1'b1;
        wait_st(0, RUN, 1'b0, 20, "t3_enter_run");
        btn_run = 1'b0;
        wait_st(0, BRK, 1'b0, 40, "t3_enter_brk");
        chk("t3_brk_hit", 32'(brk0), 1);
        chk("t3_clk_en", 32'(en0), 0);
        chk("t3_halted", 32'(halt0), 1);
        chk("t3_cnt", 32'(cnt0), 5);
        chk("t3_last_pc", pc0, 32'h14);

        // BRK holds regardless of breakpoint setting changes.
        pc0 = 32'h10;
        bp_en0 = 1'b0;
        idle(3);
        chk("t4_bp_off_stays", 32'(st0), 32'(BRK));
        bp_en0 = 1'b1;
        bp_addr0 = 32'h30;
        idle(3);
        chk("t4_addr_chg_stays", 32'(st0), 32'(BRK));
        bp_addr0 = 32'h10;
        idle(8);

        // Resume from BRK at the matching PC: no immediate re-break.
        btn_run = 1'b1;
        wait_st(0, RUN, 1'b0, 20, "t4_resume");
        chk("t4_first_pc", pc0, 32'h10);
        btn_run = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("t4_no_rebreak%0d", i), 32'(st0), 32'(RUN));
        end

        // Break again, then single-step out of BRK.
        bp_addr0 = pc0 + 32'd8;
        wait_st(0, BRK, 1'b0, 10, "t4_rebrk");
        chk("t4_rebrk_hit", 32'(brk0), 1);
        idle(8);
        btn_step = 1'b1;
        wait_st(0, STEP, 1'b0, 20, "t4_step");
        chk("t4_step_en", 32'(en0), 1);
        btn_step = 1'b0;
        tick();
        chk("t4_step_halt", 32'(st0), 32'(HALT));
        chk("t4_step_brk", 32'(brk0), 0);
        chk("t4_step_en_off", 32'(en0), 0);
        chk("t4_cnt", 32'(cnt0), 32'(ec0[7:0]));

        // Simultaneous presses: RUN wins. Then async reset mid-RUN.
        bp_en0 = 1'b0;
        idle(8);
        btn_step = 1'b1;
        btn_run = 1'b1;
        wait_st(0, HALT, 1'b1, 20, "t5_leave_halt");
        chk("t5_run_wins", 32'(st0), 32'(RUN));
        btn_step = 1'b0;
        btn_run = 1'b0;
        idle(3);
        chk("t5_still_run", 32'(st0), 32'(RUN));
        #3;
        rst_n = 1'b0;
        #1;
        chk("t5_async_en", 32'(en0), 0);
        chk("t5_async_state", 32'(st0), 32'(HALT));
        chk("t5_async_halted", 32'(halt0), 1);
        chk("t5_async_cnt", 32'(cnt0), 0);

        // 4-bit counter wrap: 17 enabled cycles to a breakpoint at 0x40.
        @(posedge clk);
        #1;
        clr_model();
        rst_n = 1'b1;
        bp_en2 = 1'b1;
        bp_addr2 = 32'h40;
        idle(2);
        btn_run = 1'b1;
        wait_st(2, RUN, 1'b0, 20, "t6_enter_run");
        btn_run = 1'b0;
        wait_st(2, BRK, 1'b0, 40, "t6_enter_brk");
        chk("t6_enabled", 32'(ec2), 17);
        chk("t6_cnt_wrap", 32'(cnt2), 1);
        chk("t6_clk_en", 32'(en2), 0);
        chk("t6_halted", 32'(halt2), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
